// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared RAM op codes, size codes and sequencer types
// Purpose: constants and types shared by the RAM port arbiter and its request checker.
// Ports:   none (package).
package mem_ctrl_pkg;

   localparam int MEM_BYTES_DEF = 512;

   // RAM ReadWrite level that means "read"
   localparam logic RW_READ = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [5:0] OP_RD_WORD = 6'b001000;
   localparam logic [5:0] OP_RD_HALF = 6'b000010;
   localparam logic [5:0] OP_RD_BYTE = 6'b000001;
   localparam logic [5:0] OP_WR_WORD = 6'b000100;
   localparam logic [5:0] OP_WR_HALF = 6'b000110;
   localparam logic [5:0] OP_WR_BYTE = 6'b000101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_FETCH = 1'b0,
      GRANT_DATA  = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_req_check.sv
// rtl/mem_req_check.sv - legality check and RAM op encoding for one request
// Purpose: decides whether a (we, size, addr) request may touch the RAM and
//          produces the matching RAM OP code.
// Ports:   we    in   1 = store
//          size  in   00 byte, 01 half, 10 word, 11 illegal
//          addr  in   byte address
//          op    out  RAM OP code for this request
//          ok    out  1 = legal, aligned and inside the RAM
module mem_req_check
   import mem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic        we,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   output logic [5:0]  op,
   output logic        ok
);

   logic [2:0]  nbytes;
   logic        legal;
   logic        aligned;
   logic [32:0] last_byte;

   always_comb begin
      nbytes  = 3'd1;
      legal   = 1'b1;
      aligned = 1'b1;
      op      = we ? OP_WR_BYTE : OP_RD_BYTE;
      case (size)
         SIZE_BYTE: nbytes = 3'd1;
         SIZE_HALF: begin
            nbytes  = 3'd2;
            aligned = ~addr[0];
            op      = we ? OP_WR_HALF : OP_RD_HALF;
         end
         SIZE_WORD: begin
            nbytes  = 3'd4;
            aligned = (addr[1:0] == 2'b00);
            op      = we ? OP_WR_WORD : OP_RD_WORD;
         end
         default: legal = 1'b0;
      endcase
      // one extra bit so an access near 0xFFFFFFFF cannot wrap back into range
      last_byte = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
      ok        = legal && aligned && (last_byte <= 33'(MEM_BYTES - 1));
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for the byte-addressed RAM
// Purpose: grants one of two requesters (round-robin on ties), rejects illegal
//          requests, drives the RAM strobes through ISSUE/WAIT with a MOC timeout
//          and returns a one-cycle done/err/rdata to the granted port.
// Ports:   clk, reset_n   clock, asynchronous active-low reset
//          if_*           instruction-fetch port (word reads only)
//          d_*            data port (byte/half/word loads and stores)
//          mem_*          RAM Enable/ReadWrite/Address/DataIn/OP, DataOut and MOC
module mem_port_arbiter
   import mem_ctrl_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        d_err,
   output logic        mem_enable,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [5:0]  mem_op,
   input  logic [31:0] mem_rdata,
   input  logic        mem_moc
);

   state_t      state_q, state_d;
   grant_t      last_grant_q, last_grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        mem_enable_q, mem_enable_d;
   logic        mem_rw_q, mem_rw_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [5:0]  mem_op_q, mem_op_d;
   logic        if_done_q, if_done_d, if_err_q, if_err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        d_done_q, d_done_d, d_err_q, d_err_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        grant_fetch;
   logic        sel_we;
   logic [1:0]  sel_size;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [5:0]  chk_op;
   logic        chk_ok;

   logic        resp_fire;
   logic        resp_fetch;
   logic        resp_err;
   logic [31:0] resp_rdata;

   // Fetch wins when alone, or on a tie when data had the previous grant.
   assign grant_fetch = if_req && (!d_req || last_grant_q == GRANT_DATA);
   assign sel_we      = grant_fetch ? 1'b0 : d_we;
   assign sel_size    = grant_fetch ? SIZE_WORD : d_size;
   assign sel_addr    = grant_fetch ? if_addr : d_addr;
   assign sel_wdata   = grant_fetch ? 32'd0 : d_wdata;

   // Checks the request being captured this cycle so IDLE can branch
   // straight to ISSUE or RESP at the grant edge.
   mem_req_check #(.MEM_BYTES(MEM_BYTES)) u_check (
      .we   (sel_we),
      .size (sel_size),
      .addr (sel_addr),
      .op   (chk_op),
      .ok   (chk_ok)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      mem_enable_d = mem_enable_q;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_op_d     = mem_op_q;
      if_done_d    = if_done_q;
      if_err_d     = if_err_q;
      if_rdata_d   = if_rdata_q;
      d_done_d     = d_done_q;
      d_err_d      = d_err_q;
      d_rdata_d    = d_rdata_q;
      resp_fire    = 1'b0;
      resp_fetch   = (last_grant_q == GRANT_FETCH);
      resp_err     = 1'b0;
      resp_rdata   = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (if_req || d_req) begin
               last_grant_d = grant_fetch ? GRANT_FETCH : GRANT_DATA;
               cnt_d        = 4'd0;
               if (chk_ok) begin
                  state_d      = ST_ISSUE;
                  mem_enable_d = 1'b1;
                  mem_rw_d     = sel_we ? ~RW_READ : RW_READ;
                  mem_addr_d   = sel_addr;
                  mem_wdata_d  = sel_wdata;
                  mem_op_d     = chk_op;
               end else begin
                  state_d    = ST_RESP;
                  resp_fire  = 1'b1;
                  resp_fetch = grant_fetch;
                  resp_err   = 1'b1;
               end
            end
         end
         // MOC still carries the previous access's level here, so it is not looked at.
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mem_moc) begin
               state_d      = ST_RESP;
               mem_enable_d = 1'b0;
               resp_fire    = 1'b1;
               resp_rdata   = (mem_rw_q == RW_READ) ? mem_rdata : 32'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == 4'(TIMEOUT)) begin
                  state_d      = ST_RESP;
                  mem_enable_d = 1'b0;
                  resp_fire    = 1'b1;
                  resp_err     = 1'b1;
               end
            end
         end
         ST_RESP: begin
            state_d    = ST_IDLE;
            if_done_d  = 1'b0;
            if_err_d   = 1'b0;
            if_rdata_d = 32'd0;
            d_done_d   = 1'b0;
            d_err_d    = 1'b0;
            d_rdata_d  = 32'd0;
         end
         default: state_d = ST_IDLE;
      endcase

      if (resp_fire) begin
         if (resp_fetch) begin
            if_done_d  = 1'b1;
            if_err_d   = resp_err;
            if_rdata_d = resp_rdata;
         end else begin
            d_done_d  = 1'b1;
            d_err_d   = resp_err;
            d_rdata_d = resp_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_DATA;
         cnt_q        <= 4'd0;
         mem_enable_q <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_op_q     <= 6'd0;
         if_done_q    <= 1'b0;
         if_err_q     <= 1'b0;
         if_rdata_q   <= 32'd0;
         d_done_q     <= 1'b0;
         d_err_q      <= 1'b0;
         d_rdata_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_enable_q <= mem_enable_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_op_q     <= mem_op_d;
         if_done_q    <= if_done_d;
         if_err_q     <= if_err_d;
         if_rdata_q   <= if_rdata_d;
         d_done_q     <= d_done_d;
         d_err_q      <= d_err_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign mem_enable = mem_enable_q;
   assign mem_rw     = mem_rw_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_op     = mem_op_q;
   assign if_done    = if_done_q;
   assign if_err     = if_err_q;
   assign if_rdata   = if_rdata_q;
   assign d_done     = d_done_q;
   assign d_err      = d_err_q;
   assign d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done, if_err;
   logic        d_req, d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata;
   logic [31:0] d_rdata;
   logic        d_done, d_err;
   logic        mem_enable, mem_rw;
   logic [31:0] mem_addr, mem_wdata;
   logic [5:0]  mem_op;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_moc;

   mem_port_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_op(mem_op), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
      end
   endtask

   // ---------------- RAM model (big-endian byte array) ----------------
   logic [7:0] ram [0:511];
   int         moc_delay = 0;
   int         ram_cnt;
   int         accesses;
   logic [5:0] last_op = 6'd0;
   logic       last_rw = 1'b0;
   logic [8:0] a0, a1, a2, a3;
   assign a0 = mem_addr[8:0];
   assign a1 = a0 + 9'd1;
   assign a2 = a0 + 9'd2;
   assign a3 = a0 + 9'd3;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_cnt  <= 0;
         mem_moc  <= 1'b0;
         accesses <= 0;
      end else if (mem_enable) begin
         if (ram_cnt == 0) begin
            accesses <= accesses + 1;
            last_op  <= mem_op;
            last_rw  <= mem_rw;
         end
         if (ram_cnt == moc_delay) begin
            mem_moc <= 1'b1;
            case (mem_op)
               OP_RD_WORD: mem_rdata <= {ram[a0], ram[a1], ram[a2], ram[a3]};
               OP_RD_HALF: mem_rdata <= {16'h0, ram[a0], ram[a1]};
               OP_RD_BYTE: mem_rdata <= {24'h0, ram[a0]};
               OP_WR_WORD: begin
                  ram[a0] <= mem_wdata[31:24];
                  ram[a1] <= mem_wdata[23:16];
                  ram[a2] <= mem_wdata[15:8];
                  ram[a3] <= mem_wdata[7:0];
               end
               OP_WR_HALF: begin
                  ram[a0] <= mem_wdata[15:8];
                  ram[a1] <= mem_wdata[7:0];
               end
               OP_WR_BYTE: ram[a0] <= mem_wdata[7:0];
               default: ;
            endcase
         end
         ram_cnt <= ram_cnt + 1;
      end else begin
         ram_cnt <= 0;
         mem_moc <= 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_fetch;
      bit          err;
      logic [31:0] rdata;
      logic [5:0]  op;
      bit          rw;
      bit          touched;
      int          exp_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];

   task automatic push(input bit f, input bit err, input logic [31:0] rd, input logic [5:0] op,
                       input bit rw, input bit touched, input int ec, input string nm);
      exp_t e;
      e.is_fetch = f; e.err = err; e.rdata = rd; e.op = op;
      e.rw = rw; e.touched = touched; e.exp_cyc = ec; e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      exp_t e;
      int   acc_prev;
      bit   f;
      acc_prev = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            acc_prev = 0;
         end else if (if_done || d_done) begin
            chk("single_done", 32'(if_done && d_done), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done if_done=%0b d_done=%0b required=none", if_done, d_done);
            end else begin
               e = sb.pop_front();
               f = if_done;
               chk({e.name, "_port"}, 32'(f), 32'(e.is_fetch));
               chk({e.name, "_err"}, 32'(f ? if_err : d_err), 32'(e.err));
               chk({e.name, "_rdata"}, f ? if_rdata : d_rdata, e.rdata);
               chk({e.name, "_other_idle"},
                   f ? (32'(d_done | d_err) | d_rdata) : (32'(if_done | if_err) | if_rdata), 32'd0);
               chk({e.name, "_cycle"}, 32'(cyc), 32'(e.exp_cyc));
               chk({e.name, "_enable_in_resp"}, 32'(mem_enable), 32'd0);
               chk({e.name, "_ram_accesses"}, 32'(accesses - acc_prev), 32'(e.touched));
               acc_prev = accesses;
               if (e.touched) begin
                  chk({e.name, "_op"}, 32'(last_op), 32'(e.op));
                  chk({e.name, "_rw"}, 32'(last_rw), 32'(e.rw));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_done(input bit fetch, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = fetch ? if_done : d_done;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_done_timeout actual=no done required=done within 60 cycles", nm);
      end
      if (fetch) if_req = 1'b0;
      else d_req = 1'b0;
   endtask

   task automatic issue(input bit fetch, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit err, input bit touched, input logic [31:0] rdata,
                        input logic [5:0] op, input int lat, input string nm);
      @(negedge clk);
      push(fetch, err, rdata, op, fetch ? 1'b1 : !we, touched, cyc + lat, nm);
      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
      end
      wait_done(fetch, nm);
   endtask

   task automatic tie(input logic [31:0] faddr, input logic [31:0] frd,
                      input logic [1:0] dsize, input logic [31:0] daddr,
                      input logic [5:0] dop, input logic [31:0] drd, input string nm);
      @(negedge clk);
      push(1'b1, 1'b0, frd, OP_RD_WORD, 1'b1, 1'b1, cyc + 3, {nm, "_fetch"});
      push(1'b0, 1'b0, drd, dop, 1'b1, 1'b1, cyc + 7, {nm, "_data"});
      if_req = 1'b1; if_addr = faddr;
      d_req = 1'b1; d_we = 1'b0; d_size = dsize; d_addr = daddr; d_wdata = 32'd0;
      wait_done(1'b1, {nm, "_fetch"});
      wait_done(1'b0, {nm, "_data"});
   endtask

   task automatic check_zero(input string p);
      chk({p, "_mem_enable"}, 32'(mem_enable), 32'd0);
      chk({p, "_mem_rw"}, 32'(mem_rw), 32'd0);
      chk({p, "_mem_op"}, 32'(mem_op), 32'd0);
      chk({p, "_mem_addr"}, mem_addr, 32'd0);
      chk({p, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({p, "_done_err"}, 32'({if_done, if_err, d_done, d_err}), 32'd0);
      chk({p, "_if_rdata"}, if_rdata, 32'd0);
      chk({p, "_d_rdata"}, d_rdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 32'd0; d_wdata = 32'd0;
      for (int i = 0; i < 512; i++) ram[i] = 8'h00;
      ram[9'h010] = 8'hDE; ram[9'h011] = 8'hAD; ram[9'h012] = 8'hBE; ram[9'h013] = 8'hEF;
      ram[9'h1FC] = 8'h11; ram[9'h1FD] = 8'h22; ram[9'h1FE] = 8'h7B; ram[9'h1FF] = 8'h9C;

      repeat (2) @(negedge clk);
      check_zero("reset");
      reset_n = 1'b1;

      // tie straight out of reset: fetch first, then the word load at the last legal word
      tie(32'h10, 32'hDEADBEEF, SIZE_WORD, 32'h1FC, OP_RD_WORD, 32'h117B229C & 32'h0 | 32'h11227B9C, "tie1");

      // fetch   we   size       addr          wdata         err  touch rdata         op          lat
      issue(1'b0, 1'b1, SIZE_HALF, 32'h22,       32'h0000ABCD, 1'b0, 1'b1, 32'h0,        OP_WR_HALF, 3, "st_half");
      issue(1'b0, 1'b0, SIZE_BYTE, 32'h23,       32'h0,        1'b0, 1'b1, 32'hCD,       OP_RD_BYTE, 3, "ld_byte");
      issue(1'b0, 1'b0, SIZE_HALF, 32'h22,       32'h0,        1'b0, 1'b1, 32'hABCD,     OP_RD_HALF, 3, "ld_half");
      issue(1'b0, 1'b1, SIZE_WORD, 32'h40,       32'hCAFEF00D, 1'b0, 1'b1, 32'h0,        OP_WR_WORD, 3, "st_word");
      issue(1'b0, 1'b1, SIZE_BYTE, 32'h41,       32'h00000077, 1'b0, 1'b1, 32'h0,        OP_WR_BYTE, 3, "st_byte");
      issue(1'b0, 1'b0, SIZE_WORD, 32'h40,       32'h0,        1'b0, 1'b1, 32'hCA77F00D, OP_RD_WORD, 3, "ld_word");
      issue(1'b0, 1'b0, SIZE_BYTE, 32'h1FF,      32'h0,        1'b0, 1'b1, 32'h9C,       OP_RD_BYTE, 3, "ld_last_byte");
      issue(1'b0, 1'b0, SIZE_HALF, 32'h1FE,      32'h0,        1'b0, 1'b1, 32'h7B9C,     OP_RD_HALF, 3, "ld_last_half");
      issue(1'b0, 1'b0, SIZE_WORD, 32'h1FE,      32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_word_1fe");
      issue(1'b0, 1'b0, SIZE_HALF, 32'h1FF,      32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_half_1ff");
      issue(1'b0, 1'b0, SIZE_WORD, 32'h1FD,      32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_word_1fd");
      issue(1'b0, 1'b0, 2'b11,     32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_size11");
      issue(1'b0, 1'b1, SIZE_BYTE, 32'h200,      32'h5,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_range");
      issue(1'b0, 1'b0, SIZE_WORD, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_wrap");
      issue(1'b1, 1'b0, SIZE_WORD, 32'h2,        32'h0,        1'b1, 1'b0, 32'h0,        6'd0,       1, "err_fetch_align");

      // MOC never arrives: 15 WAIT cycles then RESP with err
      moc_delay = 99;
      issue(1'b0, 1'b0, SIZE_WORD, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        OP_RD_WORD, 17, "timeout");

      // slow RAM: MOC on the third WAIT cycle
      moc_delay = 2;
      issue(1'b1, 1'b0, SIZE_WORD, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, OP_RD_WORD, 5, "slow_fetch");

      // reset while an access sits in WAIT; no done may appear for it
      moc_delay = 99;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_size = SIZE_WORD; d_addr = 32'h0;
      repeat (3) @(negedge clk);
      chk("pre_reset_enable", 32'(mem_enable), 32'd1);
      reset_n = 1'b0;
      d_req = 1'b0;
      #1;
      check_zero("mid_wait_reset");
      @(negedge clk);
      reset_n = 1'b1;
      moc_delay = 0;
      tie(32'h10, 32'hDEADBEEF, SIZE_BYTE, 32'h11, OP_RD_BYTE, 32'hAD, "tie2");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequencing controller and two-requester arbiter in front of the 512x8 byte-addressed RAM.
- Shares the RAM between an instruction-fetch port (word reads only) and a data port (byte/halfword/word loads and stores).
- Drives the RAM's Enable/ReadWrite/Address/DataIn/OP strobes, waits for MOC, and returns data or an error.
- Misaligned, out-of-range and illegal-size requests are rejected before the RAM is touched.

Parameters:
- MEM_BYTES, 512, RAM size in bytes; the last legal byte address is MEM_BYTES-1.
- TIMEOUT, 15, maximum WAIT cycles before MOC is declared lost (4-bit counter).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; hold it with if_addr stable until if_done.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_done=1.
- if_done  out  1  one-cycle completion pulse.
- if_err  out  1  high with if_done when the fetch failed.
- d_req  in  1  data request; hold it with its fields stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_rdata  out  32  load data, zero-extended by the RAM; valid while d_done=1.
- d_done  out  1  one-cycle completion pulse.
- d_err  out  1  high with d_done when the access failed.
- mem_enable  out  1  RAM Enable.
- mem_rw  out  1  RAM ReadWrite; 1 = read.
- mem_addr  out  32  RAM Address.
- mem_wdata  out  32  RAM DataIn.
- mem_op  out  6  RAM OP code.
- mem_rdata  in  32  RAM DataOut.
- mem_moc  in  1  RAM memory-operation-complete.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; last_grant = DATA; timeout counter = 0.
  - Every output is 0, including mem_enable, mem_rw, mem_op and both rdata buses.
  - A reset during an access abandons it; no done pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples both req lines. If only one is high, that port is granted.
  - If both are high, round-robin: grant the port that is not last_grant, so a fetch wins the first tie after reset.
  - Requester fields are captured into internal registers at grant and last_grant is updated.
  - The checker runs on the captured fields. Pass -> ISSUE. Fail -> RESP with err=1 and no RAM strobe.
- Check failure conditions:
  - d_size=11.
  - Halfword at an odd address.
  - Word (fetch or data) with addr[1:0] != 0.
  - addr + bytes - 1 > MEM_BYTES-1, evaluated at 32-bit width with no wrap.
- ISSUE (one cycle):
  - mem_enable=1; mem_rw = !we; mem_addr and mem_wdata come from the captured fields.
  - mem_op = 001000 / 000010 / 000001 for read word / half / byte.
  - mem_op = 000100 / 000110 / 000101 for write word / half / byte.
  - Fetches always use 001000.
  - mem_moc is ignored here because it still holds the previous access's stale value.
- WAIT:
  - mem_enable stays 1 and all mem_* signals stay stable.
  - When mem_moc=1 is sampled: capture mem_rdata (reads only) and go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT, go to RESP with err=1.
- RESP (one cycle):
  - mem_enable=0.
  - The granted port's done pulses, together with err, and rdata is valid. Stores return rdata=0.
  - The other port's outputs stay 0. Next state is IDLE.
- Latency:
  - Good access: req seen in IDLE at cycle N -> done at N+3 when MOC is set on the first WAIT cycle.
  - Rejected access: done+err at N+1.
- Throughput: one access per 4 cycles minimum.
- A req still high in the IDLE cycle after done counts as a new request.
- Dropping req mid-access has no effect; the access completes and done still pulses.
- mem_rdata is sampled only in WAIT.
- The counter clears on every grant.

Decomposition:
- Shared package mem_ctrl_pkg:
  - The six OP localparams.
  - SIZE_BYTE/HALF/WORD codes.
  - FSM state typedef.
  - MEM_BYTES default.
  - RW_READ=1.
- One combinational sub-module, mem_req_check: takes (we, size, addr) and returns (op, ok). It is instantiated once on the captured request.
- Arbitration, the FSM and the timeout counter live in the top module.

Test Plan:
- Fetch: if_req, if_addr=0x10, RAM preloaded DE AD BE EF at 0x10..0x13, MOC after 1 WAIT cycle -> if_done at N+3, if_rdata=0xDEADBEEF, mem_op=001000, mem_rw=1.
- Store half then load byte: d_we=1, size=01, addr=0x22, wdata=0x0000ABCD -> mem_op=000110, d_done with d_err=0. Then a byte load at 0x23 -> d_rdata=0x000000CD.
- Tie: if_req and d_req both high out of reset -> fetch granted first, data second, each done exactly once; 4+4 cycles total.
- Errors:
  - Word load at 0x1FE -> d_err=1 at N+1 with mem_enable never asserted.
  - Word at 0x1FC -> OK.
  - Halfword at 0x1FF -> d_err=1.
  - Word at 0x1FD -> d_err=1.
  - size=11 -> d_err=1.
- Timeout: mem_moc held 0 -> d_done and d_err after TIMEOUT WAIT cycles, mem_enable drops in RESP.
- Reset mid-WAIT: drive reset_n low -> all outputs 0 immediately. After release, a tie grants the fetch first and no done pulse is issued for the abandoned access.
